// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver for the CPU's memory-mapped I/O: a 2-flop synchroniser feeds a bit-centre sampling FSM.
// The received byte is held with a valid flag and ack handshake, plus sticky overrun and framing-error flags.
`timescale 1ns/1ps
module uart_rx_unit #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       UART_RX,
  input  logic       rx_ack,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [1:0]    rx_pipe;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          bit_end, load, ferr;

  // Idle-high line: the synchroniser resets to 1 so reset never looks like a start bit
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) rx_pipe <= 2'b11;
    else       rx_pipe <= {rx_pipe[0], UART_RX};

  assign rxs     = rx_pipe[1];
  assign bit_end = (cnt == CNT_BIT);
  assign load    = (state == STOP) && bit_end && rxs;
  assign ferr    = (state == STOP) && bit_end && !rxs;
  assign rx_busy = (state != IDLE);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            shift[idx] <= rxs;
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            state <= rxs ? IDLE : BREAK;
          end else cnt <= cnt + 1'b1;
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load in the same cycle as rx_ack consumes the old byte, so it is not an overrun
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (load) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (load && rx_valid && !rx_ack) overrun <= 1'b1;
      else if (clr_err)                overrun <= 1'b0;
      if (ferr)         frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed bench for uart_rx_unit at a scaled-down rate (16 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_unit;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  // Edges from the start-bit drive edge to the stop-bit sample edge
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       sys_clk, reset, UART_RX, rx_ack, clr_err;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, rx_busy;
  int         n_chk, n_err;

  uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rx_ack   (rx_ack),
    .clr_err  (clr_err),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge sys_clk); #1 UART_RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge sys_clk);
      #1 UART_RX = b[i];
    end
    repeat (CPB) @(posedge sys_clk);
    #1 UART_RX = stop;
    repeat (CPB) @(posedge sys_clk);
  endtask

  // One-cycle strobe sampled at edge n after the common starting edge
  task automatic strobe_at(input int n, input bit is_ack);
    @(posedge sys_clk);
    repeat (n - 1) @(posedge sys_clk);
    #1 if (is_ack) rx_ack = 1'b1; else clr_err = 1'b1;
    @(posedge sys_clk);
    #1 rx_ack = 1'b0; clr_err = 1'b0;
  endtask

  task automatic pulse(input bit is_ack);
    @(posedge sys_clk);
    #1 if (is_ack) rx_ack = 1'b1; else clr_err = 1'b1;
    @(posedge sys_clk);
    #1 rx_ack = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    UART_RX = 1'b1; rx_ack = 1'b0; clr_err = 1'b0; reset = 1'b0;
    #20 reset = 1'b1;
    #50 reset = 1'b0;
    #2;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_cyc(10);
      chk("idle_busy", rx_busy, 1'b0);
    end
    pulse(1'b1);
    chk("ack_no_valid", rx_valid, 1'b0);

    // Single good frame
    send_frame(8'h84, 1'b1);
    wait_cyc(2);
    chk("f1_data", rx_data, 8'h84);
    chk("f1_valid", rx_valid, 1'b1);
    chk("f1_overrun", overrun, 1'b0);
    chk("f1_ferr", frame_err, 1'b0);
    chk("f1_busy", rx_busy, 1'b0);
    pulse(1'b1);
    chk("ack_clears", rx_valid, 1'b0);
    chk("ack_data_kept", rx_data, 8'h84);

    // Back-to-back without ack -> overrun
    send_frame(8'h84, 1'b1);
    send_frame(8'h3C, 1'b1);
    wait_cyc(2);
    chk("ovr_data", rx_data, 8'h3C);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    pulse(1'b0);
    chk("ovr_cleared", overrun, 1'b0);
    chk("ovr_valid_kept", rx_valid, 1'b1);

    // Ack in the exact load cycle: load wins, no overrun
    fork
      send_frame(8'h84, 1'b1);
      strobe_at(STOP_EDGE, 1'b1);
    join
    wait_cyc(2);
    chk("ackload_data", rx_data, 8'h84);
    chk("ackload_valid", rx_valid, 1'b1);
    chk("ackload_overrun", overrun, 1'b0);

    // Stop bit low, with clr_err in the same cycle: set wins
    fork
      send_frame(8'hA5, 1'b0);
      strobe_at(STOP_EDGE, 1'b0);
    join
    #1;
    chk("fe_flag", frame_err, 1'b1);
    chk("fe_data_kept", rx_data, 8'h84);
    chk("fe_valid_kept", rx_valid, 1'b1);
    chk("fe_overrun", overrun, 1'b0);
    wait_cyc(20);
    chk("fe_break_busy", rx_busy, 1'b1);
    UART_RX = 1'b1;
    wait_cyc(5);
    chk("fe_break_exit", rx_busy, 1'b0);
    chk("fe_sticky", frame_err, 1'b1);
    pulse(1'b0);
    chk("fe_cleared", frame_err, 1'b0);

    // Short glitch on idle line is rejected by START
    @(posedge sys_clk); #1 UART_RX = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1 UART_RX = 1'b1;
    chk("gl_busy", rx_busy, 1'b1);
    wait_cyc(CPB + 4);
    chk("gl_idle", rx_busy, 1'b0);
    chk("gl_valid", rx_valid, 1'b1);
    chk("gl_data", rx_data, 8'h84);
    chk("gl_ferr", frame_err, 1'b0);

    // Reset mid-DATA aborts, then a clean frame is received
    @(posedge sys_clk); #1 UART_RX = 1'b0;
    wait_cyc(3 * CPB + 12);
    chk("mid_busy", rx_busy, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_data", rx_data, 8'h00);
    chk("mid_rst_valid", rx_valid, 1'b0);
    chk("mid_rst_busy", rx_busy, 1'b0);
    chk("mid_rst_ovr", overrun, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    UART_RX = 1'b1;
    #20 reset = 1'b0;
    wait_cyc(2);
    send_frame(8'h5A, 1'b1);
    wait_cyc(2);
    chk("post_data", rx_data, 8'h5A);
    chk("post_valid", rx_valid, 1'b1);
    chk("post_overrun", overrun, 1'b0);
    chk("post_ferr", frame_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
